// File: rtl/uart_tx.sv
// uart_tx -- buffered UART transmitter.
//
// Queues bytes written from the CPU-side register interface and serialises
// them on Txd as start bit, 7 or 8 data bits (LSB first), optional parity bit,
// then 1 or 2 stop bits. The frame format and baud encoding match the
// receiver, so one control register programs both directions.
//
// Build option:
//   UART_TX_FIFO_EN  defined     -> FIFO_DEPTH-entry circular FIFO buffer
//                    not defined -> single holding register (FIFO_DEPTH ignored)
//
// Ports:
//   Clock          sole clock
//   Reset          synchronous, active-high reset
//   DataLenLimit   data bits - 1 (6 -> 7 bits, 7 -> 8 bits)
//   StopLenLimit   stop bits - 1
//   ParityEn       append a parity bit
//   ParityPolarity 0 = even, 1 = odd parity
//   BaudLimit      clock cycles per bit - 1 (>= 1)
//   Enable         permits a new frame to start
//   TxWrite        single-cycle strobe that enqueues TxData
//   TxData         byte to send (bit 7 ignored in 7-bit mode)
//   TxFull         buffer full, writes are dropped
//   TxEmpty        buffer holds no entries
//   TxOverflow     one-cycle pulse after a dropped write
//   TxBusy         a frame is on the line
//   Txd            registered serial output, idle high

module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [2:0]  DataLenLimit,
    input  logic        StopLenLimit,
    input  logic        ParityEn,
    input  logic        ParityPolarity,
    input  logic [13:0] BaudLimit,
    input  logic        Enable,
    input  logic        TxWrite,
    input  logic [7:0]  TxData,
    output logic        TxFull,
    output logic        TxEmpty,
    output logic        TxOverflow,
    output logic        TxBusy,
    output logic        Txd
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]  state;
    logic [13:0] bit_timer;
    logic [2:0]  bit_cnt;
    logic        stop_cnt;
    logic [7:0]  shift_reg;
    logic        parity_acc;
    logic [7:0]  head_data;
    logic        bit_end;
    logic        start_frame;
    logic        push;

    assign bit_end     = (bit_timer == 14'd0);
    // The pop happens in the same idle cycle that commits to a new frame.
    assign start_frame = (state == S_IDLE) && Enable && !TxEmpty;
    // TxFull is the pre-pop value, so a write into a full buffer is dropped
    // even when an entry leaves in the same cycle.
    assign push        = TxWrite && !TxFull;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    assign head_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, start_frame})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two; the
    // flags are registered from the post-update count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            TxFull  <= 1'b0;
            TxEmpty <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (start_frame)
                rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            TxFull  <= (count_next == CNT_W'(FIFO_DEPTH));
            TxEmpty <= (count_next == '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (push)
            mem[wr_ptr] <= TxData;
    end
`else
    logic [7:0] hold_data;

    assign head_data = hold_data;
    assign TxFull    = !TxEmpty;

    // A push only happens when empty and a pop only when full, so the two
    // never coincide; the register frees up as soon as a frame starts.
    always_ff @(posedge Clock) begin
        if (Reset)
            TxEmpty <= 1'b1;
        else if (push)
            TxEmpty <= 1'b0;
        else if (start_frame)
            TxEmpty <= 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (push)
            hold_data <= TxData;
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset)
            TxOverflow <= 1'b0;
        else
            TxOverflow <= TxWrite && TxFull;
    end

    // Frame sequencer. Every bit reloads the timer with BaudLimit and ends
    // when it reads zero, giving BaudLimit + 1 cycles per bit. Parity is
    // accumulated from the bits actually driven, seeded with the polarity.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            Txd        <= 1'b1;
            TxBusy     <= 1'b0;
            bit_timer  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift_reg  <= '0;
            parity_acc <= 1'b0;
        end else begin
            if (state != S_IDLE && !bit_end)
                bit_timer <= bit_timer - 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        state      <= S_START;
                        Txd        <= 1'b0;
                        TxBusy     <= 1'b1;
                        bit_timer  <= BaudLimit;
                        shift_reg  <= head_data;
                        parity_acc <= ParityPolarity;
                        bit_cnt    <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state      <= S_DATA;
                        Txd        <= shift_reg[0];
                        parity_acc <= parity_acc ^ shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                        bit_timer  <= BaudLimit;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_timer <= BaudLimit;
                        if (bit_cnt == DataLenLimit) begin
                            bit_cnt <= '0;
                            if (ParityEn) begin
                                state <= S_PARITY;
                                Txd   <= parity_acc;
                            end else begin
                                state    <= S_STOP;
                                Txd      <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            Txd        <= shift_reg[0];
                            parity_acc <= parity_acc ^ shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state     <= S_STOP;
                        Txd       <= 1'b1;
                        stop_cnt  <= 1'b0;
                        bit_timer <= BaudLimit;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == StopLenLimit) begin
                            state  <= S_IDLE;
                            Txd    <= 1'b1;
                            TxBusy <= 1'b0;
                        end else begin
                            stop_cnt  <= 1'b1;
                            bit_timer <= BaudLimit;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    Txd    <= 1'b1;
                    TxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
// A queue-based model predicts every output each cycle; directed scenarios
// add literal frame waveforms that pin the model itself.

module tb_uart_tx;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH   = 4;
    localparam int EXP_OVF = 1;
`else
    localparam int DEPTH   = 1;
    localparam int EXP_OVF = 4;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  DataLenLimit = 3'd7;
    logic        StopLenLimit = 1'b0;
    logic        ParityEn = 1'b0;
    logic        ParityPolarity = 1'b0;
    logic [13:0] BaudLimit = 14'd3;
    logic        Enable = 1'b0;
    logic        TxWrite = 1'b0;
    logic [7:0]  TxData = 8'h00;
    logic        TxFull;
    logic        TxEmpty;
    logic        TxOverflow;
    logic        TxBusy;
    logic        Txd;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    uart_tx #(.FIFO_DEPTH(4)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .DataLenLimit(DataLenLimit),
        .StopLenLimit(StopLenLimit),
        .ParityEn(ParityEn),
        .ParityPolarity(ParityPolarity),
        .BaudLimit(BaudLimit),
        .Enable(Enable),
        .TxWrite(TxWrite),
        .TxData(TxData),
        .TxFull(TxFull),
        .TxEmpty(TxEmpty),
        .TxOverflow(TxOverflow),
        .TxBusy(TxBusy),
        .Txd(Txd)
    );

    initial forever #5 Clock = ~Clock;

    // Behavioural model: a byte queue for the buffer and a per-cycle queue of
    // line levels for the frame in flight.
    logic [7:0] m_fifo[$];
    bit         m_line[$];
    bit         m_txd = 1'b1;
    bit         m_busy = 1'b0;
    bit         m_full = 1'b0;
    bit         m_empty = 1'b1;
    bit         m_ovf = 1'b0;

    function automatic void buildFrame(input logic [7:0] data);
        bit bits[$];
        bit par;
        int nd;
        nd  = int'(DataLenLimit) + 1;
        par = ParityPolarity;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(data[i]);
            par = par ^ data[i];
        end
        if (ParityEn)
            bits.push_back(par);
        for (int i = 0; i <= int'(StopLenLimit); i++)
            bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c <= int'(BaudLimit); c++)
                m_line.push_back(bits[k]);
    endfunction

    function automatic void modelStep();
        bit was_full;
        if (Reset) begin
            m_fifo.delete();
            m_line.delete();
            m_txd   = 1'b1;
            m_busy  = 1'b0;
            m_full  = 1'b0;
            m_empty = 1'b1;
            m_ovf   = 1'b0;
        end else begin
            was_full = (m_fifo.size() == DEPTH);
            m_ovf    = TxWrite && was_full;
            if (!m_busy && Enable && m_fifo.size() > 0)
                buildFrame(m_fifo.pop_front());
            if (TxWrite && !was_full)
                m_fifo.push_back(TxData);
            m_full  = (m_fifo.size() == DEPTH);
            m_empty = (m_fifo.size() == 0);
            if (m_line.size() > 0) begin
                m_txd  = m_line.pop_front();
                m_busy = 1'b1;
            end else begin
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end
        end
    endfunction

    initial forever begin
        @(posedge Clock);
        modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge Clock);
        if (check_en) begin
            checkOutput("model_txd", Txd, m_txd);
            checkOutput("model_busy", TxBusy, m_busy);
            checkOutput("model_full", TxFull, m_full);
            checkOutput("model_empty", TxEmpty, m_empty);
            checkOutput("model_ovf", TxOverflow, m_ovf);
        end
    end

    task automatic applyStimulus(input logic [7:0] data);
        @(negedge Clock);
        TxWrite = 1'b1;
        TxData  = data;
        @(negedge Clock);
        TxWrite = 1'b0;
    endtask

    task automatic setFormat(input logic [2:0] dl, input logic sl, input logic pe,
                             input logic pp, input logic [13:0] baud);
        @(negedge Clock);
        DataLenLimit   = dl;
        StopLenLimit   = sl;
        ParityEn       = pe;
        ParityPolarity = pp;
        BaudLimit      = baud;
    endtask

    task automatic doReset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Called on the negedge of the first start-bit cycle; returns on the
    // negedge of the idle cycle that must follow the last stop bit.
    task automatic captureFrame(input string name, input int nbits, input logic [11:0] expv);
        int per;
        per = int'(BaudLimit) + 1;
        for (int c = 0; c < nbits * per; c++) begin
            if (c > 0)
                @(negedge Clock);
            checkOutput({name, "_txd"}, Txd, expv[c / per]);
            checkOutput({name, "_busy"}, TxBusy, 1);
        end
        @(negedge Clock);
        checkOutput({name, "_gap_busy"}, TxBusy, 0);
        checkOutput({name, "_gap_txd"}, Txd, 1);
    endtask

    task automatic waitStart(input string name, input int limit);
        int n;
        n = 0;
        while (!(TxBusy === 1'b1 && Txd === 1'b0) && n < limit) begin
            @(negedge Clock);
            n++;
        end
        if (n >= limit) begin
            total++;
            bad++;
            $display("[TB] FAIL %s start timeout after %0d cycles", name, limit);
        end
    endtask

    task automatic checkIdle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clock);
            checkOutput({name, "_txd"}, Txd, 1);
            checkOutput({name, "_busy"}, TxBusy, 0);
        end
    endtask

    function automatic logic [11:0] frame8n1(input logic [7:0] d);
        return {2'b00, 1'b1, d, 1'b0};
    endfunction

    initial begin
        int ovf_seen;
        logic full_seen [5];

        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        $display("[TB] reset values");
        checkOutput("rst_txd", Txd, 1);
        checkOutput("rst_busy", TxBusy, 0);
        checkOutput("rst_full", TxFull, 0);
        checkOutput("rst_empty", TxEmpty, 1);
        checkOutput("rst_ovf", TxOverflow, 0);
        check_en = 1'b1;

        $display("[TB] 8N1 0x55 baud 3");
        setFormat(3'd7, 1'b0, 1'b0, 1'b0, 14'd3);
        Enable = 1'b1;
        applyStimulus(8'h55);
        checkOutput("lat_empty_n1", TxEmpty, 0);
        checkOutput("lat_busy_n1", TxBusy, 0);
        checkOutput("lat_txd_n1", Txd, 1);
        @(negedge Clock);
        checkOutput("lat_empty_n2", TxEmpty, 1);
        captureFrame("8n1_55", 10, 12'b001010101010);

        $display("[TB] 7E2 0x83 baud 1");
        setFormat(3'd6, 1'b1, 1'b1, 1'b0, 14'd1);
        applyStimulus(8'h83);
        @(negedge Clock);
        captureFrame("7e2_03", 11, 12'b011000000110);

        $display("[TB] 8O1 parity");
        setFormat(3'd7, 1'b0, 1'b1, 1'b1, 14'd1);
        applyStimulus(8'h00);
        @(negedge Clock);
        captureFrame("8o1_00", 11, 12'b011000000000);
        applyStimulus(8'h01);
        @(negedge Clock);
        captureFrame("8o1_01", 11, 12'b010000000010);

        $display("[TB] enable dropped mid-frame");
        setFormat(3'd7, 1'b0, 1'b0, 1'b0, 14'd1);
        applyStimulus(8'hC3);
        applyStimulus(8'h3C);
        repeat (2) @(negedge Clock);
        Enable = 1'b0;
        repeat (30) @(negedge Clock);
        checkOutput("hold_busy", TxBusy, 0);
        checkOutput("hold_txd", Txd, 1);
        checkOutput("hold_empty", TxEmpty, 0);
        Enable = 1'b1;
        waitStart("resume", 10);
        captureFrame("resume_3c", 10, 12'b001001111000);

        $display("[TB] overflow with enable low");
        Enable = 1'b0;
        doReset();
        ovf_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (i > 0)
                full_seen[i-1] = TxFull;
            if (TxOverflow === 1'b1)
                ovf_seen++;
            TxWrite = 1'b1;
            TxData  = 8'hA0 + 8'(i);
        end
        @(negedge Clock);
        full_seen[4] = TxFull;
        if (TxOverflow === 1'b1)
            ovf_seen++;
        TxWrite = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            if (TxOverflow === 1'b1)
                ovf_seen++;
        end
        checkOutput("ovf_full_at_depth", full_seen[DEPTH-1], 1);
        checkOutput("ovf_pulses", ovf_seen, EXP_OVF);
        Enable = 1'b1;
        waitStart("drain", 10);
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0)
                @(negedge Clock);
            captureFrame("drain_frame", 10, frame8n1(8'hA0 + 8'(k)));
        end
        checkIdle("drain_idle", 20);

        $display("[TB] reset mid-frame");
        setFormat(3'd7, 1'b0, 1'b0, 1'b0, 14'd3);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        repeat (5) @(negedge Clock);
        checkOutput("midrst_pre_txd", Txd, 0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checkOutput("midrst_txd", Txd, 1);
        checkOutput("midrst_busy", TxBusy, 0);
        checkOutput("midrst_empty", TxEmpty, 1);
        checkOutput("midrst_full", TxFull, 0);
        checkIdle("midrst_idle", 20);

        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
